fsk_demodulation: RTL
=====================

Name: fsk_demodulation

Overview:
- Receive side of the FSK link: takes the 16-bit sine sample stream produced by fsk_modulation and recovers the binary data stream Dout.
- Measures carrier period by hysteretic rising zero-crossing detection and classifies each period as mark (high tone, 1) or space (low tone, 0).
- Applies a VOTE-deep agreement filter before updating Dout.
- Sits directly downstream of fsk_modulation; consumes one sample per clock.

Parameters:
- W, 16, sample width (offset-binary, unsigned)
- MID, 16'h8000, zero level of the sample stream
- HYST, 16'h0400, crossing hysteresis; low threshold MID-HYST, high threshold MID+HYST
- P0, 64, nominal clocks per carrier cycle for Din=0
- P1, 32, nominal clocks per carrier cycle for Din=1 (P1 < P0 required)
- CNT_W, 12, period counter width
- TIMEOUT, 256, clocks without a crossing before loss of lock (< 2^CNT_W)
- VOTE, 3, consecutive equal symbols required to change Dout (1..8)

Ports:
- clk, input, 1, system clock
- reset_n, input, 1, asynchronous active-low reset
- enable, input, 1, demodulator run enable
- in_sample, input, W, modulated sample, sampled every clk
- Dout, output, 1, recovered data bit
- sym_valid, output, 1, one-cycle pulse per accepted period measurement
- sym, output, 1, raw symbol of the last accepted period
- period, output, CNT_W, last measured period in clocks
- locked, output, 1, carrier tracking indicator
- err, output, 1, one-cycle pulse on an out-of-range period or timeout

Behaviour:
- Reset (async, reset_n=0):
  - Dout=0, sym=0, sym_valid=0, err=0, locked=0, period=0.
  - State=IDLE, counter=0, vote history cleared.
- in_sample registers into s_q every cycle. All decisions use s_q.
- States:
  - IDLE: entered when enable=0 (any state, next edge). Outputs hold except sym_valid=err=0 and locked=0; vote history cleared. enable=1 -> ACQ_LOW.
  - ACQ_LOW: wait for s_q < MID-HYST -> ACQ_HIGH.
  - ACQ_HIGH: s_q > MID+HYST is the first crossing. Counter <= 1, no measurement -> TRK_LOW.
  - TRK_LOW: s_q < MID-HYST -> TRK_HIGH.
  - TRK_HIGH: s_q > MID+HYST is a crossing. Measured value m = counter, i.e. clocks since the previous crossing cycle. Counter <= 1 -> TRK_LOW.
- Counter (ACQ_HIGH excluded, TRK_*): increments every cycle and saturates at 2^CNT_W-1.
  - counter >= TIMEOUT in TRK_*: err pulse, locked<=0, vote history cleared -> ACQ_LOW. Dout holds.
- Classification at a crossing:
  - Accept if P1/2 <= m <= 2*P0. Then period<=m and sym<=(m < (P0+P1)/2).
  - On accept: sym_valid pulses, locked<=1, sym shifts into the vote history.
  - Tie rule: m == (P0+P1)/2 classifies as 0.
  - Otherwise reject: err pulse, locked<=0, vote history cleared, state still -> TRK_LOW (keep tracking).
- Vote filter: Dout<=sym when the last VOTE accepted symbols are all equal. Updates on the same edge as sym_valid; otherwise Dout holds.
- Latency: sample presented at cycle t; crossing decision on s_q at t+1; sym_valid/sym/period/Dout visible from t+2.
- Simultaneous events: enable=0 has priority over a crossing or timeout in the same cycle (no sym_valid, no err). A crossing on the same cycle the counter reaches TIMEOUT is a crossing, not a timeout.
- Threshold and midpoint arithmetic is done at CNT_W/W width on constants; no runtime division.

Decomposition:
- Package fsk_pkg: state enum (IDLE, ACQ_LOW, ACQ_HIGH, TRK_LOW, TRK_HIGH), derived constants THR=(P0+P1)/2, PMIN=P1/2, PMAX=2*P0, LO_TH=MID-HYST, HI_TH=MID+HYST. Shared with fsk_modulation for P0/P1.
- One sub-module, fsk_vote_filter (VOTE-deep symbol history plus agreement logic). Crossing FSM and counter stay in the top module.

Test Plan:
- Reset/idle: reset_n=0 mid-stream, then enable=0 -> all outputs 0, locked=0, no sym_valid for 200 clocks of carrier.
- Space tone: square/sine with 64-clock period, enable=1 -> first sym_valid at the second crossing, period=64, sym=0; locked=1; Dout=0 after 3 pulses.
- Mark transition: switch to 32-clock period -> period=32, sym=1; Dout goes 1 on the 3rd consecutive sym=1 and not earlier.
- Boundary/glitch: single periods of 48 (->sym=0), 47 (->sym=1), 15 and 129 (->err, locked=0, history cleared, no Dout change). Samples oscillating inside MID±HYST produce no crossings.
- Timeout: hold in_sample=0xFFFF after lock -> err pulse exactly 256 clocks after the last crossing, locked=0, Dout held, state reacquires.
- End-to-end: fsk_modulation driving fsk_demodulation with bit pattern 1,0,1,1,0 at 512 clocks/bit -> Dout reproduces the pattern with constant delay ≤ VOTE*P0+2 clocks per edge.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared FSK link constants, derived thresholds and the demodulator state type.
// P0/P1 are also used by fsk_modulation, so both ends agree on the tones.
package fsk_pkg;

    localparam int W       = 16;
    localparam int CNT_W   = 12;
    localparam int P0      = 64;
    localparam int P1      = 32;
    localparam int TIMEOUT = 256;
    localparam int VOTE    = 3;

    localparam logic [W-1:0] MID  = 16'h8000;
    localparam logic [W-1:0] HYST = 16'h0400;

    localparam logic [W-1:0] LO_TH = MID - HYST;
    localparam logic [W-1:0] HI_TH = MID + HYST;

    // Period classification limits, all folded to constants at elaboration.
    localparam logic [CNT_W-1:0] THR       = CNT_W'((P0 + P1) / 2);
    localparam logic [CNT_W-1:0] PMIN      = CNT_W'(P1 / 2);
    localparam logic [CNT_W-1:0] PMAX      = CNT_W'(2 * P0);
    localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACQ_LOW  = 3'd1,
        ACQ_HIGH = 3'd2,
        TRK_LOW  = 3'd3,
        TRK_HIGH = 3'd4
    } fsk_state_e;

endpackage

// File: rtl/fsk_vote_filter.sv
// Symbol agreement filter: dout follows sym_in only once the last VOTE
// accepted symbols (since the last clear) are all identical.
module fsk_vote_filter
    import fsk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic push,
    input  logic sym_in,
    output logic dout
);

    logic [VOTE-1:0] hist;
    logic [VOTE-1:0] hist_next;
    logic [3:0]      fill;
    logic [3:0]      fill_next;
    logic            agree;

    // fill tracks how many history slots hold real symbols since the last
    // clear, so cleared zeros never count as votes.
    always_comb begin
        hist_next    = hist;
        hist_next[0] = sym_in;
        for (int i = 1; i < VOTE; i++) begin
            hist_next[i] = hist[i-1];
        end
        fill_next = (fill < 4'(VOTE)) ? fill + 4'd1 : fill;
        agree     = (fill_next == 4'(VOTE)) && ((&hist_next) || !(|hist_next));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
            dout <= 1'b0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (push) begin
            hist <= hist_next;
            fill <= fill_next;
            if (agree) begin
                dout <= sym_in;
            end
        end
    end

endmodule

// File: rtl/fsk_demodulation.sv
// FSK receiver: hysteretic rising zero-crossing period measurement, mark/space
// classification, loss-of-lock detection and a vote filter on the output bit.
module fsk_demodulation
    import fsk_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [W-1:0]     in_sample,
    output logic             Dout,
    output logic             sym_valid,
    output logic             sym,
    output logic [CNT_W-1:0] period,
    output logic             locked,
    output logic             err
);

    fsk_state_e       state, state_next;
    logic [W-1:0]     s_q;
    logic [CNT_W-1:0] counter, counter_d;
    logic [CNT_W-1:0] period_d;
    logic             sym_d, sym_valid_d, err_d, locked_d;
    logic             vote_clear, vote_push;
    logic             is_low, is_high, tracking, crossing, timeout, in_range;

    assign is_low   = (s_q < LO_TH);
    assign is_high  = (s_q > HI_TH);
    assign tracking = (state == TRK_LOW) || (state == TRK_HIGH);
    assign crossing = (state == TRK_HIGH) && is_high;
    // A crossing in the same cycle the counter hits the limit wins over timeout.
    assign timeout  = tracking && !crossing && (counter >= TMO);
    assign in_range = (counter >= PMIN) && (counter <= PMAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:     state_next = ACQ_LOW;
                ACQ_LOW:  if (is_low) state_next = ACQ_HIGH;
                ACQ_HIGH: if (is_high) state_next = TRK_LOW;
                TRK_LOW: begin
                    if (timeout)     state_next = ACQ_LOW;
                    else if (is_low) state_next = TRK_HIGH;
                end
                TRK_HIGH: begin
                    if (crossing)     state_next = TRK_LOW;
                    else if (timeout) state_next = ACQ_LOW;
                end
                default:  state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        counter_d   = counter;
        period_d    = period;
        sym_d       = sym;
        sym_valid_d = 1'b0;
        err_d       = 1'b0;
        locked_d    = locked;
        vote_clear  = 1'b0;
        vote_push   = 1'b0;
        if (!enable) begin
            counter_d  = '0;
            locked_d   = 1'b0;
            vote_clear = 1'b1;
        end else begin
            case (state)
                ACQ_HIGH: counter_d = is_high ? CNT_ONE : '0;
                TRK_LOW, TRK_HIGH: begin
                    if (crossing) begin
                        // counter equals clocks since the previous crossing cycle
                        counter_d = CNT_ONE;
                        if (in_range) begin
                            period_d    = counter;
                            sym_d       = (counter < THR);
                            sym_valid_d = 1'b1;
                            locked_d    = 1'b1;
                            vote_push   = 1'b1;
                        end else begin
                            err_d      = 1'b1;
                            locked_d   = 1'b0;
                            vote_clear = 1'b1;
                        end
                    end else if (timeout) begin
                        counter_d  = '0;
                        err_d      = 1'b1;
                        locked_d   = 1'b0;
                        vote_clear = 1'b1;
                    end else begin
                        counter_d = (counter == CNT_MAX) ? counter : counter + CNT_ONE;
                    end
                end
                default:  counter_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q       <= MID;
            counter   <= '0;
            period    <= '0;
            sym       <= 1'b0;
            sym_valid <= 1'b0;
            err       <= 1'b0;
            locked    <= 1'b0;
        end else begin
            s_q       <= in_sample;
            counter   <= counter_d;
            period    <= period_d;
            sym       <= sym_d;
            sym_valid <= sym_valid_d;
            err       <= err_d;
            locked    <= locked_d;
        end
    end

    // Sampling sym_d on push keeps Dout on the same edge as sym_valid.
    fsk_vote_filter u_vote (
        .clk    (clk),
        .rst_n  (reset_n),
        .clear  (vote_clear),
        .push   (vote_push),
        .sym_in (sym_d),
        .dout   (Dout)
    );

endmodule
